// File: rtl/cnt_seq_pkg.sv
// Shared types for the counter job scheduler.
// Provides the FSM state enum and direction encodings.
package cnt_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/mod4_updown_cnt.sv
// Two-bit modulo-4 up/down counter with wrap flag.
// Ports: clk, rst (sync, active-high), en, dir (0 up, 1 down),
//        q (count), wrap (combinational 3->0 / 0->3 marker).
module mod4_updown_cnt
    import cnt_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       dir,
    output logic [1:0] q,
    output logic       wrap
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 2'd0;
        end else if (en) begin
            q <= (dir == DIR_DOWN) ? q - 2'd1 : q + 2'd1;
        end
    end

    // Flags the step that is about to cross the modulus boundary.
    assign wrap = en & ((dir == DIR_DOWN) ? (q == 2'd0)
                                          : (q == 2'd3));

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Round-robin job scheduler driving the shared mod-4 counter.
// Ports: clk, rst, req_valid/req_dir/req_steps/req_ready (per requester),
//        done_valid/done_id/done_state/done_wraps, cnt_state, busy.
module cnt_seq_ctrl
    import cnt_seq_pkg::*;
#(
    parameter  int NREQ   = 2,
    parameter  int STEP_W = 8,
    localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_dir,
    input  logic [NREQ*STEP_W-1:0] req_steps,
    output logic [NREQ-1:0]        req_ready,
    output logic                   done_valid,
    output logic [ID_W-1:0]        done_id,
    output logic [1:0]             done_state,
    output logic [STEP_W-1:0]      done_wraps,
    output logic [1:0]             cnt_state,
    output logic                   busy
);

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    id_q;
    logic               dir_q;
    logic [STEP_W-1:0]  rem;
    logic [STEP_W-1:0]  wraps;

    logic               done_valid_q;
    logic [ID_W-1:0]    done_id_q;
    logic [1:0]         done_state_q;
    logic [STEP_W-1:0]  done_wraps_q;
    logic               busy_q;

    logic [NREQ-1:0]    pick;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_dir;
    logic [STEP_W-1:0]  gnt_steps;
    logic [ID_W-1:0]    nxt_ptr;
    logic               hs;

    logic               step_en;
    logic [1:0]         cnt_q;
    logic [1:0]         cnt_next;
    logic               wrap;
    logic [STEP_W-1:0]  wraps_inc;

    // First asserted request at or after p, searching cyclically.
    function automatic logic [NREQ-1:0] rr_pick(
        input logic [NREQ-1:0] v,
        input logic [ID_W-1:0] p
    );
        logic [NREQ-1:0] g;
        logic            hit;
        logic [ID_W-1:0] j;
        g   = '0;
        hit = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = ID_W'((int'(p) + k) % NREQ);
            if (!hit && v[j]) begin
                g[j] = 1'b1;
                hit  = 1'b1;
            end
        end
        return g;
    endfunction

    always_comb begin
        pick = '0;
        if (state == IDLE && !rst) begin
            pick = rr_pick(req_valid, ptr);
        end
        gnt_idx   = '0;
        gnt_dir   = DIR_UP;
        gnt_steps = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                gnt_idx   = ID_W'(i);
                gnt_dir   = req_dir[i];
                gnt_steps = req_steps[i*STEP_W +: STEP_W];
            end
        end
    end

    assign hs        = |pick;
    assign req_ready = pick;
    assign nxt_ptr   = (gnt_idx == ID_W'(NREQ - 1))
                     ? '0 : gnt_idx + ID_W'(1);

    assign step_en   = (state == RUN);
    assign cnt_next  = (dir_q == DIR_DOWN) ? cnt_q - 2'd1
                                           : cnt_q + 2'd1;
    assign wraps_inc = wraps + {{(STEP_W-1){1'b0}}, wrap};

    mod4_updown_cnt u_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (step_en),
        .dir  (dir_q),
        .q    (cnt_q),
        .wrap (wrap)
    );

    // done_* are loaded on the transition into DONE so that they are
    // valid in the DONE cycle itself; cnt_next is what the counter
    // will hold after the last step lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            id_q         <= '0;
            dir_q        <= DIR_UP;
            rem          <= '0;
            wraps        <= '0;
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
            done_state_q <= 2'd0;
            done_wraps_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            done_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hs) begin
                        ptr    <= nxt_ptr;
                        id_q   <= gnt_idx;
                        dir_q  <= gnt_dir;
                        rem    <= gnt_steps;
                        wraps  <= '0;
                        busy_q <= 1'b1;
                        if (gnt_steps == '0) begin
                            state        <= DONE;
                            done_valid_q <= 1'b1;
                            done_id_q    <= gnt_idx;
                            done_state_q <= cnt_q;
                            done_wraps_q <= '0;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem   <= rem - STEP_W'(1);
                    wraps <= wraps_inc;
                    if (rem == STEP_W'(1)) begin
                        state        <= DONE;
                        done_valid_q <= 1'b1;
                        done_id_q    <= id_q;
                        done_state_q <= cnt_next;
                        done_wraps_q <= wraps_inc;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign done_valid = done_valid_q;
    assign done_id    = done_id_q;
    assign done_state = done_state_q;
    assign done_wraps = done_wraps_q;
    assign cnt_state  = cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl: directed scenarios plus random traffic
// compared every cycle against a job-level arithmetic model.
module tb_cnt_seq_ctrl;

    localparam int NREQ   = 2;
    localparam int STEP_W = 8;
    localparam int ID_W   = 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ-1:0]        req_dir = '0;
    logic [NREQ*STEP_W-1:0] req_steps = '0;
    logic [NREQ-1:0]        req_ready;
    logic                   done_valid;
    logic [ID_W-1:0]        done_id;
    logic [1:0]             done_state;
    logic [STEP_W-1:0]      done_wraps;
    logic [1:0]             cnt_state;
    logic                   busy;

    cnt_seq_ctrl #(.NREQ(NREQ), .STEP_W(STEP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_dir    (req_dir),
        .req_steps  (req_steps),
        .req_ready  (req_ready),
        .done_valid (done_valid),
        .done_id    (done_id),
        .done_state (done_state),
        .done_wraps (done_wraps),
        .cnt_state  (cnt_state),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s @cycle %0d: got timeout expected event",
                 nm, cyc);
    endtask

    function automatic int mod4(input int x);
        return ((x % 4) + 4) % 4;
    endfunction

    // Up: one wrap each time c+k reaches a multiple of 4.
    // Down: one wrap each time the value leaves 0.
    function automatic int wraps_of(input int c, input int n,
                                    input logic d);
        return d ? (n + 3 - c) / 4 : (c + n) / 4;
    endfunction

    function automatic logic [NREQ-1:0] rr_ref(
        input logic [NREQ-1:0] v, input int p);
        logic [NREQ-1:0] r;
        r = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (r == '0 && v[(p + k) % NREQ])
                r[(p + k) % NREQ] = 1'b1;
        end
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    bit   known = 0;
    bit   j_act = 0;
    int   j_t, j_n, j_start, j_id;
    logic j_dir;
    int   m_cnt = 0, m_ptr = 0;
    int   m_id = 0, m_state = 0, m_wraps = 0;

    always @(negedge clk) begin : model
        int k, kk, e_cnt;
        logic e_busy, e_dv;
        logic [NREQ-1:0] e_ready;
        e_dv = 1'b0;
        if (j_act) begin
            k  = cyc - j_t - 1;
            kk = (k > j_n) ? j_n : k;
            e_cnt  = mod4(j_start + (j_dir ? -kk : kk));
            e_busy = 1'b1;
            if (k == j_n) begin
                e_dv    = 1'b1;
                m_id    = j_id;
                m_state = mod4(j_start + (j_dir ? -j_n : j_n));
                m_wraps = wraps_of(j_start, j_n, j_dir);
            end
        end else begin
            e_cnt  = m_cnt;
            e_busy = 1'b0;
        end
        e_ready = (j_act || rst) ? '0 : rr_ref(req_valid, m_ptr);
        if (known || rst) chk("mdl_ready", 32'(req_ready), 32'(e_ready));
        if (known) begin
            chk("mdl_busy", 32'(busy), 32'(e_busy));
            chk("mdl_cnt", 32'(cnt_state), 32'(e_cnt));
            chk("mdl_dv", 32'(done_valid), 32'(e_dv));
            chk("mdl_did", 32'(done_id), 32'(m_id));
            chk("mdl_dstate", 32'(done_state), 32'(m_state));
            chk("mdl_dwraps", 32'(done_wraps), 32'(m_wraps));
        end
        if (rst) begin
            j_act = 0; m_cnt = 0; m_ptr = 0;
            m_id = 0; m_state = 0; m_wraps = 0;
            known = 1;
        end else if (j_act && e_dv) begin
            j_act = 0;
            m_cnt = m_state;
        end else if (!j_act && e_ready != '0) begin
            for (int i = 0; i < NREQ; i++) begin
                if (e_ready[i]) begin
                    j_id    = i;
                    j_dir   = req_dir[i];
                    j_n     = int'(req_steps[i*STEP_W +: STEP_W]);
                    m_ptr   = (i + 1) % NREQ;
                end
            end
            j_act   = 1;
            j_t     = cyc;
            j_start = m_cnt;
        end
    end

    // ---------------- stimulus ----------------
    task automatic accept(input int id, input logic d,
                          input logic [STEP_W-1:0] s, output int t);
        @(posedge clk); #1;
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_dir[id] = d;
        req_steps[id*STEP_W +: STEP_W] = s;
        t = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) fail_now("accept_wait");
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog @cycle %0d: got no finish expected finish",
                 cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t, g;
        int gid[4];
        int gcy[4];
        logic [1:0] c2[6];
        logic [1:0] c3[4];
        logic [NREQ-1:0] gm;

        // 1. reset with all requests asserted; 4. arbitration
        req_valid = '1;
        req_dir = '0;
        req_steps = {8'd1, 8'd1};
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready0", 32'(req_ready), 0);
        @(negedge clk);
        chk("rst_ready1", 32'(req_ready), 0);
        chk("rst_dv", 32'(done_valid), 0);
        chk("rst_cnt", 32'(cnt_state), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", 32'(req_ready), 32'h1);
        g = 0;
        for (int n = 0; n < 40 && g < 4; n++) begin
            if (n > 0) @(negedge clk);
            if (req_ready != '0) begin
                gid[g] = int'(req_ready[1]);
                gcy[g] = cyc;
                g++;
            end
        end
        if (g < 4) begin
            fail_now("arb_wait");
        end else begin
            chk("arb_g0", 32'(gid[0]), 0);
            chk("arb_g1", 32'(gid[1]), 1);
            chk("arb_g2", 32'(gid[2]), 0);
            chk("arb_g3", 32'(gid[3]), 1);
            for (int i = 1; i < 4; i++)
                chk("arb_gap", 32'(gcy[i] - gcy[i-1]), 3);
        end
        @(posedge clk); #1;
        req_valid = '0;

        // 2. req0 up 5 from 0
        c2 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        accept(0, 1'b0, 8'd5, t);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("up_cnt", 32'(cnt_state), 32'(c2[k-1]));
            chk("up_dv", 32'(done_valid), (k == 6) ? 1 : 0);
        end
        chk("up_id", 32'(done_id), 0);
        chk("up_state", 32'(done_state), 1);
        chk("up_wraps", 32'(done_wraps), 1);

        // 3. req1 down 3 from 1
        c3 = '{2'd1, 2'd0, 2'd3, 2'd2};
        accept(1, 1'b1, 8'd3, t);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("dn_cnt", 32'(cnt_state), 32'(c3[k-1]));
            chk("dn_dv", 32'(done_valid), (k == 4) ? 1 : 0);
        end
        chk("dn_id", 32'(done_id), 1);
        chk("dn_state", 32'(done_state), 2);
        chk("dn_wraps", 32'(done_wraps), 1);

        // 5. zero steps at cnt 2
        accept(0, 1'b0, 8'd0, t);
        @(negedge clk);
        chk("z_dv", 32'(done_valid), 1);
        chk("z_busy", 32'(busy), 1);
        chk("z_state", 32'(done_state), 2);
        chk("z_wraps", 32'(done_wraps), 0);
        chk("z_cnt", 32'(cnt_state), 2);
        @(negedge clk);
        chk("z_busy_off", 32'(busy), 0);
        chk("z_dv_off", 32'(done_valid), 0);

        // 6. reset in 4th RUN cycle of a 10-step job
        accept(0, 1'b0, 8'd10, t);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_cnt", 32'(cnt_state), 0);
        for (int k = 0; k < 12; k++) begin
            chk("mr_no_done", 32'(done_valid), 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        req_steps = {8'd1, 8'd1};
        req_valid = '1;
        @(negedge clk);
        chk("mr_grant0", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = '0;

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            gm = req_ready & req_valid;
            @(posedge clk); #1;
            rst = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && gm[i]) begin
                    req_valid[i] = 1'b0;
                end else if (req_valid[i]) begin
                    if ($urandom_range(0, 63) == 0)
                        req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_dir[i] = 1'($urandom_range(0, 1));
                    req_steps[i*STEP_W +: STEP_W] =
                        ($urandom_range(0, 15) == 0)
                        ? 8'($urandom_range(0, 60))
                        : 8'($urandom_range(0, 6));
                end
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        repeat (80) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cnt_seq_ctrl.md
# cnt_seq_ctrl

Job scheduler for the shared 2-bit modulo-4 up/down sequence counter. It arbitrates round-robin between NREQ requesters. Each accepted job runs the counter a given number of steps in a given direction. On completion the block reports the final counter state and the number of wrap events. It sits between the requesting blocks and the counter, which it instantiates.

## Interface
- NREQ, 2: number of requesters (2..8)
- STEP_W, 8: width of step count and wrap count (≥ 2)
- ID_W, max(1, clog2(NREQ)): requester index width (derived)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous and active-high. Only clk and rst, one clock.
- req_valid  in  NREQ  job request, one bit per requester
- req_dir  in  NREQ  direction per requester; 0 = up, 1 = down
- req_steps  in  NREQ*STEP_W  step count; requester i uses bits [i*STEP_W +: STEP_W]
- req_ready  out  NREQ  one-hot grant/accept strobe
- done_valid  out  1  one-cycle job completion pulse
- done_id  out  ID_W  index of the completed requester
- done_state  out  2  counter value after the last step
- done_wraps  out  STEP_W  wrap events during the job
- cnt_state  out  2  live counter value
- busy  out  1  high when not in IDLE

## Operation
- FSM states and transitions:
  - IDLE: goes to RUN when a job is accepted with steps ≠ 0.
  - IDLE: goes to DONE when a job is accepted with steps = 0.
  - RUN: goes to DONE when the last step is issued (remaining = 1).
  - DONE: always returns to IDLE.
- Arbitration:
  - Only in IDLE.
  - Grant goes to the first asserted req_valid at or after pointer `ptr`, searching cyclically.
  - req_ready is combinational, one-hot to the granted index, and only in IDLE. It is all-zero otherwise.
  - Handshake = req_valid[i] & req_ready[i].
  - On handshake, `ptr` becomes (i+1) mod NREQ.
- Accept latches dir, steps, and id. It clears the wrap count and loads remaining = steps.
- Requesters hold dir/steps stable while valid. Dropping valid before the handshake is legal, and no job is created.
- In RUN each cycle:
  - Assert step enable with the latched dir.
  - The counter moves +1 (up) or −1 (down) mod 4.
  - remaining decrements.
  - wrap count increments on a wrap.
- Wrap definitions:
  - Up: the counter goes 3→0.
  - Down: the counter goes 0→3.
- Wrap count cannot overflow: at most ceil(N/4) wraps in N steps, which fits STEP_W.
- DONE: done_valid = 1 for exactly one cycle, with done_id, done_state = cnt_state, and done_wraps.
  - No backpressure on done.
  - done_id, done_state, and done_wraps hold their values until the next DONE.
- Counter value persists across jobs. Only rst clears it.
- Reset values: FSM IDLE, ptr 0, counter 0, remaining 0.
  - All outputs are 0 (req_ready 0 during rst).
- rst mid-job: the job is dropped silently, with no done_valid. The state on the next cycle is the reset state.

## Timing
- Handshake at cycle t:
  - Steps take effect on the counter at edges t+1..t+N.
  - done_valid is high in cycle t+N+1.
  - steps = 0 gives done_valid at t+1, with the counter unchanged.
- A job occupies N+2 cycles, counting the accept cycle. The next accept is at the earliest in the cycle after DONE.
- cnt_state and busy are registered outputs. req_ready is combinational from req_valid and ptr.

## Structure
- Package cnt_seq_pkg contains:
  - FSM state enum: IDLE, RUN, DONE.
  - DIR_UP = 0, DIR_DOWN = 1.
- Sub-module mod4_updown_cnt:
  - Ports: clk, rst, en, dir, q[1:0], wrap.
  - wrap is combinational: en & (dir ? q==0 : q==3).
  - The counter changes only when en = 1.
- Round-robin pick is a function in the controller, not a separate module.

## Test plan
1. Reset:
   - Stimulus: rst for 2 cycles with all req_valid = 1.
   - Required: req_ready = 0, done_valid = 0, cnt_state = 0, busy = 0. After release, req_ready = 01.
2. Up job:
   - Stimulus: req0 up, steps = 5 from cnt 0.
   - Required: cnt_state 1,2,3,0,1. done_valid at t+6 with done_id = 0, done_state = 1, done_wraps = 1.
3. Down job:
   - Stimulus: req1 down, steps = 3 from cnt 1.
   - Required: cnt_state 0,3,2. done_state = 2, done_wraps = 1, done_id = 1.
4. Arbitration:
   - Stimulus: req0 and req1 held valid continuously after reset, steps = 1 each.
   - Required: grant order is 0,1,0,1. There are 3 cycles between successive accepts.
5. Zero steps:
   - Stimulus: req0 with steps = 0 at cnt 2.
   - Required: done_valid at t+1, done_wraps = 0, done_state = 2, busy high for 1 cycle.
6. Reset mid-job:
   - Stimulus: steps = 10, rst asserted in the 4th RUN cycle.
   - Required: next cycle IDLE, cnt_state = 0, busy = 0. No done_valid ever for that job. ptr = 0, so a subsequent req0+req1 grants 0.
